// File: rtl/hazard_controller_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_controller_pkg;

   // Width of the saturating stall-cycle counter.
   localparam int WIDTH = 32;

   // Execute-stage forwarding selects.
   localparam logic [1:0] FWD_REG = 2'b00;  // register file operand
   localparam logic [1:0] FWD_WB  = 2'b01;  // result_wb
   localparam logic [1:0] FWD_MEM = 2'b10;  // aluout_mem

   // MULT/DIV sequencer states.
   typedef enum logic [0:0] {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // Register 0 is hardwired to zero, so it can never carry a dependency.
   function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

endpackage

// File: rtl/hazard_controller_md_sequencer.sv
// MULT/DIV sequencer: issues HI/LO operations, counts busy cycles and
// holds decode while a HI/LO result is still outstanding.
module hazard_controller_md_sequencer
   import hazard_controller_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic md_start_decode,
   input  logic md_div_decode,
   input  logic hilo_read_decode,
   input  logic hazard_block,     // load-use or branch stall this cycle
   output logic md_issue,
   output logic md_busy,
   output logic md_done,
   output logic mdstall
);

   md_state_t        r_state;
   md_state_t        w_state_next;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;

   // State and busy-counter registers; reset abandons any in-flight op.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= MD_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
      end
   end

   // Next-state, counter and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      md_issue     = 1'b0;
      md_busy      = 1'b0;
      md_done      = 1'b0;
      case (r_state)
         MD_IDLE: begin
            // An instruction that is itself stalled in decode must not start the unit.
            md_issue = md_start_decode && !hazard_block;
            if (md_issue) begin
               w_count_next = md_div_decode ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               w_state_next = MD_BUSY;
            end
         end
         MD_BUSY: begin
            md_busy      = 1'b1;
            w_count_next = r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
               md_done      = 1'b1;
               w_state_next = MD_IDLE;
            end
         end
         default: begin
            w_state_next = MD_IDLE;
         end
      endcase
   end

   // Any HI/LO consumer or new HI/LO producer waits until the unit is free.
   assign mdstall = md_busy && (md_start_decode || hilo_read_decode);

endmodule

// File: rtl/hazard_controller.sv
// Central hazard/stall controller for the 5-stage pipeline: forwarding
// selects, load-use and branch-compare stalls, and MULT/DIV sequencing.
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs_decode,
   input  logic [4:0]       Rt_decode,
   input  logic [4:0]       Rs_execute,
   input  logic [4:0]       Rt_execute,
   input  logic [4:0]       writereg_execute,
   input  logic [4:0]       writereg_mem,
   input  logic [4:0]       writereg_wb,
   input  logic             regwrite_execute,
   input  logic             regwrite_mem,
   input  logic             regwrite_wb,
   input  logic             memtoreg_execute,
   input  logic             memtoreg_mem,
   input  logic             branch_decode,
   input  logic             md_start_decode,
   input  logic             md_div_decode,
   input  logic             hilo_read_decode,
   output logic             stall_fetch,
   output logic             stall_decode,
   output logic             flush_execute,
   output logic             forwardA_decode,
   output logic             forwardB_decode,
   output logic [1:0]       forwardA_execute,
   output logic [1:0]       forwardB_execute,
   output logic             md_issue,
   output logic             md_busy,
   output logic             md_done,
   output logic [WIDTH-1:0] stall_cycles
);

   logic             w_lwstall;
   logic             w_brstall;
   logic             w_mdstall;
   logic             w_stall;
   logic [WIDTH-1:0] r_stall_cycles;

   // Execute-stage forwarding; the younger MEM result wins over WB.
   always_comb begin
      forwardA_execute = FWD_REG;
      forwardB_execute = FWD_REG;
      if (regwrite_mem && reg_match(writereg_mem, Rs_execute))
         forwardA_execute = FWD_MEM;
      else if (regwrite_wb && reg_match(writereg_wb, Rs_execute))
         forwardA_execute = FWD_WB;
      if (regwrite_mem && reg_match(writereg_mem, Rt_execute))
         forwardB_execute = FWD_MEM;
      else if (regwrite_wb && reg_match(writereg_wb, Rt_execute))
         forwardB_execute = FWD_WB;
   end

   // Decode-stage forwarding feeds the early branch comparator from MEM.
   assign forwardA_decode = regwrite_mem && reg_match(writereg_mem, Rs_decode);
   assign forwardB_decode = regwrite_mem && reg_match(writereg_mem, Rt_decode);

   // Load in execute whose data decode needs: one bubble.
   assign w_lwstall = memtoreg_execute &&
                      (reg_match(writereg_execute, Rs_decode) ||
                       reg_match(writereg_execute, Rt_decode));

   // Branch compares in decode, so it waits for ALU results in execute
   // and for loads still in memory.
   assign w_brstall = branch_decode &&
                      ((regwrite_execute &&
                        (reg_match(writereg_execute, Rs_decode) ||
                         reg_match(writereg_execute, Rt_decode))) ||
                       (memtoreg_mem &&
                        (reg_match(writereg_mem, Rs_decode) ||
                         reg_match(writereg_mem, Rt_decode))));

   hazard_controller_md_sequencer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_sequencer (
      .clk               (clk),
      .rst               (rst),
      .md_start_decode   (md_start_decode),
      .md_div_decode     (md_div_decode),
      .hilo_read_decode  (hilo_read_decode),
      .hazard_block      (w_lwstall || w_brstall),
      .md_issue          (md_issue),
      .md_busy           (md_busy),
      .md_done           (md_done),
      .mdstall           (w_mdstall)
   );

   assign w_stall       = w_lwstall || w_brstall || w_mdstall;
   assign stall_fetch   = w_stall;
   assign stall_decode  = w_stall;
   assign flush_execute = w_stall;

   // Saturating count of stalled cycles for performance monitoring.
   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cycles <= '0;
      else if (stall_decode && (r_stall_cycles != '1))
         r_stall_cycles <= r_stall_cycles + WIDTH'(1);
   end

   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: each step drives one decode-cycle
// of inputs, queues the expected outputs, then pops and compares them.
module tb_hazard_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  Rs_decode, Rt_decode, Rs_execute, Rt_execute;
   logic [4:0]  writereg_execute, writereg_mem, writereg_wb;
   logic        regwrite_execute, regwrite_mem, regwrite_wb;
   logic        memtoreg_execute, memtoreg_mem;
   logic        branch_decode, md_start_decode, md_div_decode, hilo_read_decode;
   logic        stall_fetch, stall_decode, flush_execute;
   logic        forwardA_decode, forwardB_decode;
   logic [1:0]  forwardA_execute, forwardB_execute;
   logic        md_issue, md_busy, md_done;
   logic [31:0] stall_cycles;

   hazard_controller #(
      .MULT_CYCLES (4),
      .DIV_CYCLES  (32),
      .CNT_W       (6)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .Rs_decode        (Rs_decode),
      .Rt_decode        (Rt_decode),
      .Rs_execute       (Rs_execute),
      .Rt_execute       (Rt_execute),
      .writereg_execute (writereg_execute),
      .writereg_mem     (writereg_mem),
      .writereg_wb      (writereg_wb),
      .regwrite_execute (regwrite_execute),
      .regwrite_mem     (regwrite_mem),
      .regwrite_wb      (regwrite_wb),
      .memtoreg_execute (memtoreg_execute),
      .memtoreg_mem     (memtoreg_mem),
      .branch_decode    (branch_decode),
      .md_start_decode  (md_start_decode),
      .md_div_decode    (md_div_decode),
      .hilo_read_decode (hilo_read_decode),
      .stall_fetch      (stall_fetch),
      .stall_decode     (stall_decode),
      .flush_execute    (flush_execute),
      .forwardA_decode  (forwardA_decode),
      .forwardB_decode  (forwardB_decode),
      .forwardA_execute (forwardA_execute),
      .forwardB_execute (forwardB_execute),
      .md_issue         (md_issue),
      .md_busy          (md_busy),
      .md_done          (md_done),
      .stall_cycles     (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_entry_t;

   sb_entry_t   sb_q[$];
   int          total_cnt = 0;
   int          bad_cnt   = 0;
   logic [31:0] exp_stall_cnt;
   int          step_no = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         0:  return {31'd0, stall_fetch};
         1:  return {31'd0, stall_decode};
         2:  return {31'd0, flush_execute};
         3:  return {31'd0, forwardA_decode};
         4:  return {31'd0, forwardB_decode};
         5:  return {30'd0, forwardA_execute};
         6:  return {30'd0, forwardB_execute};
         7:  return {31'd0, md_issue};
         8:  return {31'd0, md_busy};
         9:  return {31'd0, md_done};
         default: return stall_cycles;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] exp);
      sb_entry_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic clear_inputs();
      Rs_decode = 0; Rt_decode = 0; Rs_execute = 0; Rt_execute = 0;
      writereg_execute = 0; writereg_mem = 0; writereg_wb = 0;
      regwrite_execute = 0; regwrite_mem = 0; regwrite_wb = 0;
      memtoreg_execute = 0; memtoreg_mem = 0;
      branch_decode = 0; md_start_decode = 0; md_div_decode = 0; hilo_read_decode = 0;
   endtask

   // Inputs are already driven just after a falling edge; queue expectations,
   // sample 2 time units later (well before the rising edge), move on.
   task automatic step(input string name, input bit st, input bit fad, input bit fbd,
                       input logic [1:0] fea, input logic [1:0] feb,
                       input bit iss, input bit bsy, input bit dn);
      sb_entry_t e;
      push({name, ".stall_fetch"}, 0, {31'd0, st});
      push({name, ".stall_decode"}, 1, {31'd0, st});
      push({name, ".flush_execute"}, 2, {31'd0, st});
      push({name, ".fwdA_dec"}, 3, {31'd0, fad});
      push({name, ".fwdB_dec"}, 4, {31'd0, fbd});
      push({name, ".fwdA_ex"}, 5, {30'd0, fea});
      push({name, ".fwdB_ex"}, 6, {30'd0, feb});
      push({name, ".md_issue"}, 7, {31'd0, iss});
      push({name, ".md_busy"}, 8, {31'd0, bsy});
      push({name, ".md_done"}, 9, {31'd0, dn});
      push({name, ".stall_cycles"}, 10, exp_stall_cnt);
      // Counter model: the stall seen now is counted at the coming edge.
      if (rst)
         exp_stall_cnt = 32'd0;
      else if (st && exp_stall_cnt != 32'hFFFF_FFFF)
         exp_stall_cnt = exp_stall_cnt + 32'd1;
      #2;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, observe(e.sel), e.exp);
      end
      $display("step %0d %s: stall=%0b fwdEx=%0b/%0b fwdDec=%0b/%0b issue=%0b busy=%0b done=%0b cnt=%0h",
               step_no, name, stall_decode, forwardA_execute, forwardB_execute,
               forwardA_decode, forwardB_decode, md_issue, md_busy, md_done, stall_cycles);
      step_no++;
      @(negedge clk);
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      exp_stall_cnt = 32'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      step("reset", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

      // Load-use on Rs: one bubble, then the load sits in MEM and forwards to decode
      clear_inputs();
      memtoreg_execute = 1; regwrite_execute = 1; writereg_execute = 5'd2; Rs_decode = 5'd2;
      step("lw_use", 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      clear_inputs();
      memtoreg_mem = 1; regwrite_mem = 1; writereg_mem = 5'd2; Rs_decode = 5'd2;
      step("lw_after", 0, 1, 0, 2'b00, 2'b00, 0, 0, 0);
      // Load to r0 is never a hazard
      clear_inputs();
      memtoreg_execute = 1; regwrite_execute = 1; writereg_execute = 5'd0;
      step("lw_r0", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

      // Execute forwarding priority
      clear_inputs();
      regwrite_mem = 1; regwrite_wb = 1; writereg_mem = 5'd5; writereg_wb = 5'd5;
      Rs_execute = 5'd5; Rt_execute = 5'd5;
      step("fwd_mem", 0, 0, 0, 2'b10, 2'b10, 0, 0, 0);
      regwrite_mem = 0;
      step("fwd_wb", 0, 0, 0, 2'b01, 2'b01, 0, 0, 0);
      regwrite_mem = 1; writereg_mem = 5'd0; writereg_wb = 5'd0; Rs_execute = 5'd0; Rt_execute = 5'd0;
      step("fwd_r0", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      clear_inputs();
      regwrite_mem = 1; regwrite_wb = 1; writereg_mem = 5'd9; writereg_wb = 5'd3;
      Rs_execute = 5'd3; Rt_execute = 5'd9;
      step("fwd_split", 0, 0, 0, 2'b01, 2'b10, 0, 0, 0);

      // Branch compare on an ALU result, then forwarded from MEM
      clear_inputs();
      branch_decode = 1; regwrite_execute = 1; writereg_execute = 5'd7; Rt_decode = 5'd7; Rs_decode = 5'd1;
      step("br_exe", 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      clear_inputs();
      branch_decode = 1; regwrite_mem = 1; writereg_mem = 5'd7; Rt_decode = 5'd7; Rs_decode = 5'd1;
      step("br_fwd", 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
      // Branch waiting on a load in MEM
      memtoreg_mem = 1;
      step("br_ldmem", 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);

      // MULT blocked by a load-use hazard in the same cycle
      clear_inputs();
      md_start_decode = 1; memtoreg_execute = 1; writereg_execute = 5'd4; Rs_decode = 5'd4;
      step("mult_blk", 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);

      // MULT issue, MFLO waits through the busy window
      clear_inputs();
      md_start_decode = 1;
      step("mult_iss", 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
      clear_inputs();
      hilo_read_decode = 1;
      for (int i = 1; i <= 4; i++)
         step($sformatf("mflo_b%0d", i), 1, 0, 0, 2'b00, 2'b00, 0, 1, (i == 4));
      step("mflo_go", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

      // Back-to-back MULT: second waits, issues in first idle cycle
      clear_inputs();
      md_start_decode = 1;
      step("mult2_iss", 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
      for (int i = 1; i <= 4; i++)
         step($sformatf("mult3_w%0d", i), 1, 0, 0, 2'b00, 2'b00, 0, 1, (i == 4));
      step("mult3_iss", 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
      clear_inputs();
      for (int i = 1; i <= 4; i++)
         step($sformatf("mult3_b%0d", i), 0, 0, 0, 2'b00, 2'b00, 0, 1, (i == 4));

      // DIV abandoned by reset in its 5th busy cycle
      md_start_decode = 1; md_div_decode = 1;
      step("div_iss", 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
      clear_inputs();
      for (int i = 1; i <= 4; i++)
         step($sformatf("div_b%0d", i), 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
      rst = 1'b1;
      step("div_rst", 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
      rst = 1'b0;
      step("post_rst", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      md_start_decode = 1;
      step("mult_after_rst", 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
      clear_inputs();
      for (int i = 1; i <= 4; i++)
         step($sformatf("mult4_b%0d", i), 0, 0, 0, 2'b00, 2'b00, 0, 1, (i == 4));

      // Saturation: preload near all-ones, then keep stalling
      force dut.r_stall_cycles = 32'hFFFF_FFFD;
      #1;
      release dut.r_stall_cycles;
      exp_stall_cnt = 32'hFFFF_FFFD;
      memtoreg_execute = 1; writereg_execute = 5'd6; Rt_decode = 5'd6;
      for (int i = 0; i < 4; i++)
         step($sformatf("sat%0d", i), 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      clear_inputs();
      step("sat_hold", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central hazard and stall controller for the 5-stage MIPS pipeline.
- Produces decode-stage and execute-stage forwarding selects, and load-use and branch-compare stalls.
- Sequences the multi-cycle MULT/DIV (HI/LO) unit: issues operations, tracks busy cycles, and holds decode while HI/LO results are outstanding.
- Sits beside the decode stage; drives the F/D register enables and the D/E register clear, and supplies forwardA_decode/forwardB_decode to decode.

Parameters:
- MULT_CYCLES, 4, busy cycles for MULT/MULTU (legal range 1..63).
- DIV_CYCLES, 32, busy cycles for DIV/DIVU (legal range 1..63).
- CNT_W, 6, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- Rs_decode, Rt_decode  input  5 each  source registers of the instruction in decode.
- Rs_execute, Rt_execute  input  5 each  source registers in execute.
- writereg_execute, writereg_mem, writereg_wb  input  5 each  destination registers per stage.
- regwrite_execute, regwrite_mem, regwrite_wb  input  1 each  register-write enables per stage.
- memtoreg_execute, memtoreg_mem  input  1 each  stage holds a load.
- branch_decode  input  1  branch instruction in decode.
- md_start_decode  input  1  MULT/DIV instruction in decode.
- md_div_decode  input  1  1 = DIV/DIVU, 0 = MULT/MULTU (valid with md_start_decode).
- hilo_read_decode  input  1  MFHI/MFLO in decode.
- stall_fetch  output  1  hold PC.
- stall_decode  output  1  hold F/D register.
- flush_execute  output  1  clear D/E register (bubble).
- forwardA_decode, forwardB_decode  output  1 each  select aluout_mem for the branch compare.
- forwardA_execute, forwardB_execute  output  2 each  00 = regfile, 01 = result_wb, 10 = aluout_mem.
- md_issue  output  1  one-cycle start pulse to the MULT/DIV datapath.
- md_busy  output  1  MULT/DIV operation in flight.
- md_done  output  1  one-cycle pulse in the final busy cycle.
- stall_cycles  output  `WIDTH  saturating count of stalled cycles.

Behaviour:
- Reset: rst sampled on the clk edge. It clears the FSM to IDLE, the busy counter to 0, md_busy/md_done/md_issue to 0, and stall_cycles to 0. Reset mid-operation abandons the in-flight op; md_done does not pulse.
- Register 0 is never a hazard source: any match on register 0 is ignored.
- Execute forwarding (combinational), for A (B identical, using Rt_execute):
  - 10 if regwrite_mem and writereg_mem == Rs_execute.
  - Else 01 if regwrite_wb and writereg_wb == Rs_execute.
  - Else 00.
  - MEM has priority over WB.
- Decode forwarding: forwardA_decode = regwrite_mem and writereg_mem == Rs_decode; forwardB_decode likewise with Rt_decode.
- lwstall = memtoreg_execute and writereg_execute matches Rs_decode or Rt_decode.
- brstall = branch_decode and either:
  - regwrite_execute and writereg_execute matches Rs_decode or Rt_decode, or
  - memtoreg_mem and writereg_mem matches Rs_decode or Rt_decode.
- mdstall = md_busy and (md_start_decode or hilo_read_decode).
- stall_fetch = stall_decode = flush_execute = lwstall | brstall | mdstall.
- MULT/DIV FSM states: IDLE, BUSY.
  - IDLE: md_issue = md_start_decode and not lwstall and not brstall (combinational). On issue, the counter loads DIV_CYCLES or MULT_CYCLES per md_div_decode, and the FSM goes to BUSY next cycle.
  - BUSY: md_busy = 1. The counter decrements each cycle. md_done = 1 when counter == 1. At counter == 1 the FSM returns to IDLE next cycle.
  - Issue in cycle T gives md_busy in cycles T+1..T+N and md_done in cycle T+N. A dependent MFHI/MFLO in decode leaves decode at T+N+1 at the earliest.
  - md_issue is never asserted while BUSY. A second MULT/DIV waits via mdstall and issues in the first IDLE cycle.
- Simultaneous hazards: stall outputs are a pure OR of causes. The load-use and branch checks still gate md_issue in IDLE.
- stall_cycles: +1 on every clk edge where stall_decode = 1. It holds at all-ones and never wraps.

Decomposition:
- defines.v already provides `WIDTH. Add to it:
  - the FWD_REG/FWD_WB/FWD_MEM 2-bit encodings;
  - the MD_IDLE/MD_BUSY state encodings.
- One sub-module is natural: md_sequencer, containing the FSM, busy counter, md_issue/md_busy/md_done logic and mdstall.
- Forwarding and the load/branch stall logic stay in the top level.

Test Plan:
- LW r2 in execute, decode reads Rs = 2 → stall_fetch = stall_decode = flush_execute = 1 for exactly 1 cycle; stall_cycles goes 0→1.
- writereg_mem = writereg_wb = 5, both regwrite, Rs_execute = 5 → forwardA_execute = 10. Then with regwrite_mem = 0 → 01. With writereg = 0 and Rs = 0 → 00.
- BEQ in decode with regwrite_execute, writereg_execute = Rt_decode = 7 → brstall for 1 cycle. Next cycle, with the producer in mem, forwardB_decode = 1 and no stall.
- MULT issued at cycle 10 with MULT_CYCLES = 4 → md_issue at cycle 10; md_busy at cycles 11–14; md_done at 14. MFLO in decode from cycle 11 stalls through 14 and advances at 15.
- DIV issued, then rst asserted in the 5th busy cycle → next cycle md_busy = 0, md_done never pulses, stall_cycles = 0. A MULT presented after reset issues immediately.
- Force 2^32+3 stall cycles (or preload via hierarchical force) → stall_cycles saturates at 0xFFFFFFFF.
